countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer_pkg.sv | 38 +++
 rtl/countdown_timer_bcd_down_digit.sv | 49 ++++
 rtl/countdown_timer.sv | 149 ++++++++++++++
 tb/tb_countdown_timer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer_pkg
// Description : Shared definitions for the countdown timer: BCD digit width,
//               per-digit maximum values, FSM state encoding and a helper
//               that sizes the sub-second counter.
// Ports       : (package, no ports)
// Revision    : 1.0 - initial release
// ============================================================================
package countdown_timer_pkg;

   localparam int BCD_W = 4;

   // Largest value a digit may hold: units digits roll to 9, the tens of
   // seconds digit rolls to 5.
   localparam logic [BCD_W-1:0] DIGIT_MAX_9 = 4'd9;
   localparam logic [BCD_W-1:0] DIGIT_MAX_5 = 4'd5;

   localparam int STATE_W = 2;
   localparam logic [STATE_W-1:0] S_IDLE    = 2'd0;
   localparam logic [STATE_W-1:0] S_PAUSED  = 2'd1;
   localparam logic [STATE_W-1:0] S_RUNNING = 2'd2;
   localparam logic [STATE_W-1:0] S_EXPIRED = 2'd3;

   // The sub-second counter is shared between the running phase (counts to
   // TICKS_PER_SEC) and the alarm phase (counts to ALARM_SECS*TICKS_PER_SEC),
   // so it is sized for the larger of the two. Never narrower than one bit.
   function automatic int cnt_width(input int ticks_per_sec, input int alarm_secs);
      int m;
      m = ticks_per_sec;
      if (alarm_secs * ticks_per_sec > m) begin
         m = alarm_secs * ticks_per_sec;
      end
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage : countdown_timer_pkg
`default_nettype wire

// File: rtl/countdown_timer_bcd_down_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_down_digit
// Description : One BCD down-counting digit. Loads a value (clamped to
//               MAX_VAL), decrements when enabled and wraps 0 -> MAX_VAL.
// Ports       : clk        - clock
//               rst        - synchronous active-high reset (digit -> 0)
//               i_load     - load strobe (has priority over decrement)
//               i_load_val - value to load, clamped to MAX_VAL
//               i_dec_en   - decrement this digit on this edge
//               o_digit    - current digit value
//               o_borrow   - digit is zero, so a decrement borrows from the
//                            next digit up
// Revision    : 1.0 - initial release
// ============================================================================
import countdown_timer_pkg::*;

module bcd_down_digit #(
   parameter logic [BCD_W-1:0] MAX_VAL = DIGIT_MAX_9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [BCD_W-1:0] i_load_val,
   input  logic             i_dec_en,
   output logic [BCD_W-1:0] o_digit,
   output logic             o_borrow
);

   logic [BCD_W-1:0] r_digit;
   logic [BCD_W-1:0] w_load_clamped;

   assign w_load_clamped = (i_load_val > MAX_VAL) ? MAX_VAL : i_load_val;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_digit <= '0;
      end else if (i_load) begin
         r_digit <= w_load_clamped;
      end else if (i_dec_en) begin
         r_digit <= (r_digit == '0) ? MAX_VAL : (r_digit - 1'b1);
      end
   end

   assign o_digit  = r_digit;
   assign o_borrow = (r_digit == '0);

endmodule : bcd_down_digit
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : MM:SS BCD countdown timer with pause/resume and a timed
//               alarm after expiry.
// Ports       : clk         - clock, rising edge
//               reset       - synchronous active-high reset
//               tick        - one-cycle pulse from the shared divider
//               load        - capture load_digits (IDLE/PAUSED/EXPIRED)
//               load_digits - BCD {min_tens, min_ones, sec_tens, sec_ones}
//               start       - begin/resume countdown from PAUSED
//               stop        - pause countdown or silence the alarm
//               digits      - current time, same packing as load_digits
//               running     - high in RUNNING
//               alarm       - high in EXPIRED
//               done        - one-cycle pulse on entry to EXPIRED
// Revision    : 1.0 - initial release
// ============================================================================
import countdown_timer_pkg::*;

module countdown_timer #(
   parameter int TICKS_PER_SEC = 10,
   parameter int ALARM_SECS    = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   input  logic        load,
   input  logic [15:0] load_digits,
   input  logic        start,
   input  logic        stop,
   output logic [15:0] digits,
   output logic        running,
   output logic        alarm,
   output logic        done
);

   localparam int CNT_W = cnt_width(TICKS_PER_SEC, ALARM_SECS);
   localparam logic [CNT_W-1:0] C_SEC_LAST   = CNT_W'(TICKS_PER_SEC - 1);
   localparam logic [CNT_W-1:0] C_ALARM_LAST = CNT_W'(ALARM_SECS * TICKS_PER_SEC - 1);

   logic [STATE_W-1:0] r_state;
   logic [CNT_W-1:0]   r_sub_cnt;
   logic               r_done;

   logic [15:0]        w_digits;
   logic [3:0]         w_borrow;
   logic [3:0]         w_dec_en;
   logic               w_load_acc;
   logic               w_sec_dec;
   logic               w_time_zero;
   logic               w_last_sec;

   // A stop strobe always masks the lower-priority strobes, even in states
   // where stop itself does nothing. Load is only acted on outside RUNNING.
   assign w_load_acc  = load && !stop && (r_state != S_RUNNING);

   assign w_time_zero = &w_borrow;

   // Current time is 00:01, so the coming decrement lands on 00:00.
   assign w_last_sec  = (&w_borrow[3:1]) && (w_digits[3:0] == 4'd1);

   // One-second decrement: last tick of the second while running. The
   // time-zero guard keeps the chain from ever wrapping below 00:00.
   assign w_sec_dec   = (r_state == S_RUNNING) && !stop && tick &&
                        (r_sub_cnt == C_SEC_LAST) && !w_time_zero;

   // Digit order: 0 = sec_ones, 1 = sec_tens, 2 = min_ones, 3 = min_tens.
   // Each digit decrements when the one below it is decrementing from zero.
   generate
      for (genvar k = 0; k < 4; k++) begin : g_digit
         localparam logic [BCD_W-1:0] C_MAX = (k == 1) ? DIGIT_MAX_5 : DIGIT_MAX_9;

         if (k == 0) begin : g_lsd
            assign w_dec_en[k] = w_sec_dec;
         end else begin : g_upper
            assign w_dec_en[k] = w_dec_en[k-1] && w_borrow[k-1];
         end

         bcd_down_digit #(
            .MAX_VAL (C_MAX)
         ) u_digit (
            .clk        (clk),
            .rst        (reset),
            .i_load     (w_load_acc),
            .i_load_val (load_digits[k*BCD_W +: BCD_W]),
            .i_dec_en   (w_dec_en[k]),
            .o_digit    (w_digits[k*BCD_W +: BCD_W]),
            .o_borrow   (w_borrow[k])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_sub_cnt <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (stop) begin
            if (r_state == S_RUNNING) begin
               // Sub-second count kept so a resume continues mid-second.
               r_state <= S_PAUSED;
            end else if (r_state == S_EXPIRED) begin
               r_state   <= S_IDLE;
               r_sub_cnt <= '0;
            end
         end else if (w_load_acc) begin
            r_state   <= S_PAUSED;
            r_sub_cnt <= '0;
         end else if (start && (r_state == S_PAUSED) && !w_time_zero) begin
            r_state <= S_RUNNING;
         end else if (tick) begin
            case (r_state)
               S_RUNNING: begin
                  if (r_sub_cnt == C_SEC_LAST) begin
                     r_sub_cnt <= '0;
                     if (w_last_sec) begin
                        r_state <= S_EXPIRED;
                        r_done  <= 1'b1;
                     end
                  end else begin
                     r_sub_cnt <= r_sub_cnt + 1'b1;
                  end
               end
               // The alarm duration reuses the sub-second counter.
               S_EXPIRED: begin
                  if (r_sub_cnt == C_ALARM_LAST) begin
                     r_state   <= S_IDLE;
                     r_sub_cnt <= '0;
                  end else begin
                     r_sub_cnt <= r_sub_cnt + 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign digits  = w_digits;
   assign running = (r_state == S_RUNNING);
   assign alarm   = (r_state == S_EXPIRED);
   assign done    = r_done;

endmodule : countdown_timer
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown_timer
// Description : Self-checking bench for countdown_timer with
//               TICKS_PER_SEC=2, ALARM_SECS=2. A vector table drives one
//               cycle per entry; expected outputs go through a scoreboard
//               queue and are compared just after the clock edge. A final
//               hand-written sequence covers a long countdown to expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

   logic        clk;
   logic        reset;
   logic        tick;
   logic        load;
   logic [15:0] load_digits;
   logic        start;
   logic        stop;
   logic [15:0] digits;
   logic        running;
   logic        alarm;
   logic        done;

   countdown_timer #(
      .TICKS_PER_SEC (2),
      .ALARM_SECS    (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .load        (load),
      .load_digits (load_digits),
      .start       (start),
      .stop        (stop),
      .digits      (digits),
      .running     (running),
      .alarm       (alarm),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        rst;
      logic        tk;
      logic        ld;
      logic        st;
      logic        sp;
      logic [15:0] ldv;
      logic [15:0] e_digits;
      logic        e_run;
      logic        e_alarm;
      logic        e_done;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];

   int n_pass  = 0;
   int n_total = 0;

   task automatic add(input string n, input logic r, input logic tk, input logic ld,
                      input logic st, input logic sp, input logic [15:0] ldv,
                      input logic [15:0] ed, input logic er, input logic ea,
                      input logic edn);
      vec_t v;
      v.name = n; v.rst = r; v.tk = tk; v.ld = ld; v.st = st; v.sp = sp;
      v.ldv = ldv; v.e_digits = ed; v.e_run = er; v.e_alarm = ea; v.e_done = edn;
      vecs.push_back(v);
   endtask

   task automatic check(input string n, input logic [15:0] ed, input logic er,
                        input logic ea, input logic edn);
      n_total++;
      if ({digits, running, alarm, done} === {ed, er, ea, edn}) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got digits=%h running=%b alarm=%b done=%b, expected digits=%h running=%b alarm=%b done=%b",
                  n, digits, running, alarm, done, ed, er, ea, edn);
      end
   endtask

   task automatic check_int(input string n, input int got, input int exp);
      n_total++;
      if (got == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", n, got, exp);
      end
   endtask

   task automatic idle_inputs();
      reset = 1'b0; tick = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
      load_digits = 16'h0000;
   endtask

   initial begin
      vec_t v;
      vec_t e;
      int   n_ticks;
      bit   seen_done;

      idle_inputs();
      reset = 1'b1;

      //    name            rst tk ld st sp ldv       digits   run al dn
      add("reset",          1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
      add("idle_tick",      0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
      add("idle_start",     0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);
      // Three-second countdown through expiry and the alarm window
      add("a_load",         0, 0, 1, 0, 0, 16'h0003, 16'h0003, 0, 0, 0);
      add("a_start",        0, 0, 0, 1, 0, 16'h0000, 16'h0003, 1, 0, 0);
      add("a_t1",           0, 1, 0, 0, 0, 16'h0000, 16'h0003, 1, 0, 0);
      add("a_t2",           0, 1, 0, 0, 0, 16'h0000, 16'h0002, 1, 0, 0);
      add("a_gap",          0, 0, 0, 0, 0, 16'h0000, 16'h0002, 1, 0, 0);
      add("a_t3",           0, 1, 0, 0, 0, 16'h0000, 16'h0002, 1, 0, 0);
      add("a_t4",           0, 1, 0, 0, 0, 16'h0000, 16'h0001, 1, 0, 0);
      add("a_t5",           0, 1, 0, 0, 0, 16'h0000, 16'h0001, 1, 0, 0);
      add("a_t6_done",      0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1);
      add("a_done_clear",   0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0);
      add("a_al_t1",        0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0);
      add("a_al_t2",        0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0);
      add("a_al_t3",        0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0);
      add("a_al_t4_off",    0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
      add("a_idle_after",   0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
      // Full borrow chain 10:00 -> 09:59
      add("b_load",         0, 0, 1, 0, 0, 16'h1000, 16'h1000, 0, 0, 0);
      add("b_start",        0, 0, 0, 1, 0, 16'h0000, 16'h1000, 1, 0, 0);
      add("b_t1",           0, 1, 0, 0, 0, 16'h0000, 16'h1000, 1, 0, 0);
      add("b_t2_borrow",    0, 1, 0, 0, 0, 16'h0000, 16'h0959, 1, 0, 0);
      add("b_stop",         0, 1, 0, 0, 1, 16'h0000, 16'h0959, 0, 0, 0);
      // Pause keeps the sub-second count, paused ticks ignored
      add("c_load",         0, 0, 1, 0, 0, 16'h0005, 16'h0005, 0, 0, 0);
      add("c_start",        0, 0, 0, 1, 0, 16'h0000, 16'h0005, 1, 0, 0);
      add("c_t1",           0, 1, 0, 0, 0, 16'h0000, 16'h0005, 1, 0, 0);
      add("c_stop_tick",    0, 1, 0, 0, 1, 16'h0000, 16'h0005, 0, 0, 0);
      add("c_pt1",          0, 1, 0, 0, 0, 16'h0000, 16'h0005, 0, 0, 0);
      add("c_pt2",          0, 1, 0, 0, 0, 16'h0000, 16'h0005, 0, 0, 0);
      add("c_pt3",          0, 1, 0, 0, 0, 16'h0000, 16'h0005, 0, 0, 0);
      add("c_resume",       0, 0, 0, 1, 0, 16'h0000, 16'h0005, 1, 0, 0);
      add("c_t2_dec",       0, 1, 0, 0, 0, 16'h0000, 16'h0004, 1, 0, 0);
      add("c_stop",         0, 0, 0, 0, 1, 16'h0000, 16'h0004, 0, 0, 0);
      // Load clamping and zero-time start
      add("d_clamp_ffff",   0, 0, 1, 0, 0, 16'hFFFF, 16'h9959, 0, 0, 0);
      add("d_clamp_a5c7",   0, 0, 1, 0, 0, 16'hA5C7, 16'h9557, 0, 0, 0);
      add("d_clamp_6a0b",   0, 0, 1, 0, 0, 16'h6A0B, 16'h6909, 0, 0, 0);
      add("d_clamp_0060",   0, 0, 1, 0, 0, 16'h0060, 16'h0050, 0, 0, 0);
      add("d_load_zero",    0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
      add("d_start_zero",   0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);
      add("d_tick_zero",    0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
      // Strobe priority and stop during EXPIRED
      add("e_load",         0, 0, 1, 0, 0, 16'h0002, 16'h0002, 0, 0, 0);
      add("e_start_stop",   0, 0, 0, 1, 1, 16'h0000, 16'h0002, 0, 0, 0);
      add("e_start",        0, 0, 0, 1, 0, 16'h0000, 16'h0002, 1, 0, 0);
      add("e_load_running", 0, 0, 1, 0, 0, 16'h1234, 16'h0002, 1, 0, 0);
      add("e_t1",           0, 1, 0, 0, 0, 16'h0000, 16'h0002, 1, 0, 0);
      add("e_t2",           0, 1, 0, 0, 0, 16'h0000, 16'h0001, 1, 0, 0);
      add("e_t3",           0, 1, 0, 0, 0, 16'h0000, 16'h0001, 1, 0, 0);
      add("e_t4_done",      0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1);
      add("e_stop_alarm",   0, 1, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);
      add("e_idle_tick",    0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
      // Load while EXPIRED clears the alarm
      add("f_load",         0, 0, 1, 0, 0, 16'h0001, 16'h0001, 0, 0, 0);
      add("f_start",        0, 0, 0, 1, 0, 16'h0000, 16'h0001, 1, 0, 0);
      add("f_t1",           0, 1, 0, 0, 0, 16'h0000, 16'h0001, 1, 0, 0);
      add("f_t2_done",      0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1);
      add("f_load_expired", 0, 0, 1, 0, 0, 16'h0007, 16'h0007, 0, 0, 0);
      add("f_start2",       0, 0, 0, 1, 0, 16'h0000, 16'h0007, 1, 0, 0);
      // Reset mid-RUNNING with tick, then mid-EXPIRED with strobes
      add("g_t1",           0, 1, 0, 0, 0, 16'h0000, 16'h0007, 1, 0, 0);
      add("g_rst_running",  1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
      add("g_start_idle",   0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);
      add("h_load",         0, 0, 1, 0, 0, 16'h0001, 16'h0001, 0, 0, 0);
      add("h_start",        0, 0, 0, 1, 0, 16'h0000, 16'h0001, 1, 0, 0);
      add("h_t1",           0, 1, 0, 0, 0, 16'h0000, 16'h0001, 1, 0, 0);
      add("h_rst_last_tick",1, 1, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);
      add("h_after_rst",    0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);

      @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         reset = v.rst; tick = v.tk; load = v.ld; start = v.st; stop = v.sp;
         load_digits = v.ldv;
         exp_q.push_back(v);
         @(posedge clk);
         #1;
         idle_inputs();
         e = exp_q.pop_front();
         check(e.name, e.e_digits, e.e_run, e.e_alarm, e.e_done);
      end

      // 00:10 at two ticks per second: done must appear after exactly 20
      // ticks, with 00:09 showing after the second tick.
      load = 1'b1; load_digits = 16'h0010;
      @(posedge clk); #1; idle_inputs();
      start = 1'b1;
      @(posedge clk); #1; idle_inputs();
      n_ticks   = 0;
      seen_done = 1'b0;
      for (int i = 0; i < 40 && !seen_done; i++) begin
         tick = 1'b1;
         @(posedge clk); #1; idle_inputs();
         n_ticks++;
         if (n_ticks == 2) begin
            check("long_after_2_ticks", 16'h0009, 1'b1, 1'b0, 1'b0);
         end
         if (done === 1'b1) begin
            seen_done = 1'b1;
         end
      end
      check_int("long_ticks_to_done", n_ticks, 20);
      check("long_expired", 16'h0000, 1'b0, 1'b1, 1'b1);
      @(posedge clk); #1;
      check("long_done_single", 16'h0000, 1'b0, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_countdown_timer
`default_nettype wire
